// File: rtl/id_hazard_scheduler_pkg.sv
// Shared defines for the ID-stage hazard scheduler: widths, scoreboard slot indices
// and the slot record.
package id_hazard_scheduler_pkg;

    localparam int WORD_LEN          = 16;
    localparam int REG_FILE_ADDR_LEN = 4;

    localparam int SLOT_EXE  = 0;
    localparam int SLOT_MEM  = 1;
    localparam int SLOT_WB   = 2;
    localparam int NUM_SLOTS = 3;

    typedef struct packed {
        logic                         valid;
        logic [REG_FILE_ADDR_LEN-1:0] dest;
        logic                         load;
    } slot_t;

endpackage

// File: rtl/id_hazard_scheduler_slot_match.sv
// Compares one scoreboard slot against the ID instruction's source registers.
// R0 is never a dependency, and src2 only counts when it is really read.
module hazard_slot_match
    import id_hazard_scheduler_pkg::*;
(
    input  slot_t                        slot,
    input  logic [REG_FILE_ADDR_LEN-1:0] src1,
    input  logic [REG_FILE_ADDR_LEN-1:0] src2,
    input  logic                         src2_valid,
    output logic                         match1,
    output logic                         match2
);

    logic unused_load;

    assign match1 = slot.valid && (src1 != '0) && (slot.dest == src1);
    assign match2 = slot.valid && src2_valid && (src2 != '0) && (slot.dest == src2);

    assign unused_load = slot.load;

endmodule

// File: rtl/id_hazard_scheduler.sv
// ID-stage RAW hazard scheduler: EXE/MEM/WB write scoreboard, stall/freeze/flush and a
// saturating stall counter. Define FORWARDING_EN when the EXE/MEM forwarding unit exists.
module id_hazard_scheduler #(
    parameter int WORD_LEN          = 16,
    parameter int REG_FILE_ADDR_LEN = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [REG_FILE_ADDR_LEN-1:0] src1,
    input  logic [REG_FILE_ADDR_LEN-1:0] src2,
    input  logic                         src2_valid,
    input  logic [REG_FILE_ADDR_LEN-1:0] dest,
    input  logic                         wb_en,
    input  logic                         mem_r_en,
    input  logic                         is_branch,
    input  logic                         br_taken,
    output logic                         hazard_detected,
    output logic                         freeze,
    output logic                         flush,
    output logic [WORD_LEN-1:0]          stall_count
);

    import id_hazard_scheduler_pkg::*;

    function automatic logic [WORD_LEN-1:0] sat_inc(input logic [WORD_LEN-1:0] v);
        return (&v) ? v : v + {{(WORD_LEN-1){1'b0}}, 1'b1};
    endfunction

    logic [NUM_SLOTS-1:0]         slot_vld;
    logic [REG_FILE_ADDR_LEN-1:0] slot_dest [NUM_SLOTS];
    logic                         slot_ld   [NUM_SLOTS];
    slot_t                        slots     [NUM_SLOTS];
    logic [NUM_SLOTS-1:0]         m1, m2;
    logic                         hit_exe, hit_mem, stall_raw;
    logic                         new_vld;
    logic                         unused_sinks;

    always_comb begin
        for (int i = 0; i < NUM_SLOTS; i++) begin
            slots[i].valid = slot_vld[i];
            slots[i].dest  = slot_dest[i];
            slots[i].load  = slot_ld[i];
        end
    end

    for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_match
        hazard_slot_match u_match (
            .slot       (slots[g]),
            .src1       (src1),
            .src2       (src2),
            .src2_valid (src2_valid),
            .match1     (m1[g]),
            .match2     (m2[g])
        );
    end

    assign hit_exe = m1[SLOT_EXE] || m2[SLOT_EXE];
    assign hit_mem = m1[SLOT_MEM] || m2[SLOT_MEM];

    // WB never stalls: the register file writes before the ID read.
`ifdef FORWARDING_EN
    assign stall_raw = (hit_exe && slot_ld[SLOT_EXE])
                    || (is_branch && hit_exe)
                    || (is_branch && hit_mem && slot_ld[SLOT_MEM]);
    assign unused_sinks = ^{m1[SLOT_WB], m2[SLOT_WB], slot_ld[SLOT_WB]};
`else
    assign stall_raw = hit_exe || hit_mem;
    assign unused_sinks = ^{m1[SLOT_WB], m2[SLOT_WB], is_branch,
                            slot_ld[SLOT_EXE], slot_ld[SLOT_MEM], slot_ld[SLOT_WB]};
`endif

    assign hazard_detected = !rst && stall_raw;
    assign freeze          = hazard_detected;
    assign flush           = !rst && br_taken && !stall_raw;
    assign new_vld         = !hazard_detected && wb_en && (dest != '0);

    // Scoreboard shift (EXE -> MEM -> WB) and stall counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot_vld    <= '0;
            stall_count <= '0;
        end else begin
            slot_vld[SLOT_WB]  <= slot_vld[SLOT_MEM];
            slot_vld[SLOT_MEM] <= slot_vld[SLOT_EXE];
            slot_vld[SLOT_EXE] <= new_vld;
            if (hazard_detected) begin
                stall_count <= sat_inc(stall_count);
            end
        end
    end

    always_ff @(posedge clk) begin
        slot_dest[SLOT_WB]  <= slot_dest[SLOT_MEM];
        slot_dest[SLOT_MEM] <= slot_dest[SLOT_EXE];
        slot_dest[SLOT_EXE] <= dest;
        slot_ld[SLOT_WB]    <= slot_ld[SLOT_MEM];
        slot_ld[SLOT_MEM]   <= slot_ld[SLOT_EXE];
        slot_ld[SLOT_EXE]   <= mem_r_en;
    end

endmodule

// File: doc/id_hazard_scheduler.md
# id_hazard_scheduler

Sequencing controller for the instruction-decode stage of the 16-bit pipeline. It keeps a three-slot scoreboard of in-flight register writes (EXE, MEM, WB) and detects read-after-write hazards against the instruction currently in ID. It drives the decode stage's hazard input, the IF/ID freeze and the IF flush on taken branches. It also keeps a saturating count of stall cycles for performance debug.

## Interface
- `WORD_LEN`, 16: data word width; only the width of `stall_count` depends on it.
- `REG_FILE_ADDR_LEN`, 4: register address width.
- `clk`  in  1  pipeline clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous and active-high.
- `src1`  in  REG_FILE_ADDR_LEN  first source register of the ID instruction.
- `src2`  in  REG_FILE_ADDR_LEN  second source register (register-file port 2 address).
- `src2_valid`  in  1  `src2` is really read: register operand, store or BNE.
- `dest`  in  REG_FILE_ADDR_LEN  destination register of the ID instruction.
- `wb_en`  in  1  the ID instruction writes `dest`.
- `mem_r_en`  in  1  the ID instruction is a load.
- `is_branch`  in  1  the ID instruction compares operands in ID (branch command ≠ 0).
- `br_taken`  in  1  the decode stage resolved a taken branch this cycle.
- `hazard_detected`  out  1  stall request to decode; zeroes the control signals passed to EXE.
- `freeze`  out  1  hold PC and the IF/ID register.
- `flush`  out  1  clear the IF/ID register on the next edge.
- `stall_count`  out  WORD_LEN  saturating count of stall cycles.

## Operation
- Each scoreboard slot holds {valid, dest, load}. Slot order is EXE, MEM, WB.
- Every edge the slots shift: WB←MEM, MEM←EXE, EXE←new entry.
- The new entry is a bubble (valid=0) when `hazard_detected`=1.
- Otherwise the new entry is {wb_en && dest≠0, dest, mem_r_en}. R0 writes are never tracked.
- A source "matches" a slot when the slot is valid and slot.dest equals that source. `src2` counts only when `src2_valid`=1, and src 0 never matches.
- The register file is write-through (WB writes before the ID read), so the WB slot never causes a hazard.
- Hazard rule (default, forwarding absent): `hazard_detected`=1 if any source matches the EXE or MEM slot.
- `freeze` = `hazard_detected`.
- `flush` = `br_taken` && !`hazard_detected`. A stalled branch produces no flush; it re-resolves when re-presented.
- `stall_count` increments on every edge where `hazard_detected`=1 and saturates at all-ones.

## Timing
- `hazard_detected`, `freeze` and `flush` are combinational from the inputs and the registered scoreboard, valid in the same cycle as the ID instruction.
- Scoreboard and `stall_count` update on the rising edge of `clk`.
- While `rst`=1: all slots are invalid, `stall_count`=0, and `hazard_detected`, `freeze`, `flush` are 0. They are forced low regardless of inputs.
- Reset asserted mid-stall clears the scoreboard immediately. The first edge after release inserts the ID instruction with no stall.
- Without forwarding, a dependent instruction directly behind its producer stalls 2 cycles and proceeds when the producer reaches WB.
- `br_taken` and `hazard_detected` in the same cycle: the hazard wins and `flush`=0.

## Configuration
- `FORWARDING_EN` defined: the EXE/MEM forwarding unit exists, and the hazard rule becomes any of the following:
  - any source matches an EXE slot with load=1 (load-use), or
  - `is_branch`=1 and any source matches the EXE slot, or
  - `is_branch`=1 and any source matches a MEM slot with load=1.
  - Under this rule, load-use stalls 1 cycle, and a branch behind an ALU producer stalls 1 cycle.
- `FORWARDING_EN` undefined: the default rule above applies, and the load flag is stored but unused.

## Structure
- Slot-index constants (EXE=0, MEM=1, WB=2) and the slot record typedef {valid, dest, load} go in the shared defines package, next to `WORD_LEN` and `REG_FILE_ADDR_LEN`.
- One sub-module, `hazard_slot_match`: compares one slot against src1/src2/src2_valid and outputs match1 and match2. It is instantiated three times.

## Test plan
- Reset: `rst`=1 with src1=3 and a valid producer of R3 pending. Required: hazard=freeze=flush=0 and stall_count=0; after release, no stall.
- ADD R3 then SUB R4,R3,R5 (no forwarding). Required: hazard=1 for exactly 2 cycles, EXE receives 2 bubbles, stall_count=2.
- Same sequence with `FORWARDING_EN`: hazard=0. Then LD R3 followed by ADD R4,R3,R1: hazard=1 for 1 cycle.
- Immediate instruction with src2 field=R3 and src2_valid=0, behind a producer of R3 in EXE: hazard=0. A producer writing R0, followed by a read of R0: hazard=0.
- Taken BNE with no dependency: flush=1 for 1 cycle and freeze=0. BNE on R2 with an R2 producer in EXE and br_taken=1: flush=0 and hazard=1.
- Preload stall_count to 16'hFFFE by forcing long stalls, then continue stalling: the count reaches 16'hFFFF and holds.
